seq_load_initiator: RTL and testbench
=====================================

SEQ_LOAD_INITIATOR -- requirements
Module: seq_load_initiator

Interface
REQ-001 SHALL have parameter CNT_W, default 4, the width of the load-count request and the progress count.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum wait in cycles for done or ready.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to begin a load burst; sampled only in IDLE.
REQ-006 num_loads  input  CNT_W  number of load_mem pulses in the burst; captured when start is accepted.
REQ-007 done  input  1  responder acknowledge for the outstanding load.
REQ-008 ready  input  1  responder indication that the loaded sequence is ready.
REQ-009 load_mem  output  1  single-cycle load request pulse to the responder.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 complete  output  1  single-cycle pulse when a burst finishes successfully.
REQ-012 timeout_err  output  1  sticky error flag; cleared only by reset or an accepted start.
REQ-013 load_cnt  output  CNT_W  number of loads acknowledged in the current burst.

Function
REQ-014 SHALL implement the states IDLE, LOAD, WAIT_DONE, WAIT_READY and ERR.
REQ-015 IDLE: start=1 with num_loads>0 SHALL capture num_loads, clear load_cnt and timeout_err, and go to LOAD next cycle.
REQ-016 IDLE: start=1 with num_loads=0 SHALL pulse complete the next cycle with no load_mem and stay in IDLE.
REQ-017 LOAD SHALL drive load_mem=1 for exactly one cycle and then go to WAIT_DONE.
REQ-018 WAIT_DONE SHALL sample done from the cycle after load_mem; done asserted in the same cycle as load_mem SHALL be ignored.
REQ-019 WAIT_DONE with done=1 SHALL increment load_cnt, then go to LOAD if load_cnt+1<captured count, else to WAIT_READY.
REQ-020 WAIT_READY with ready=1 SHALL pulse complete one cycle later and go to IDLE; ready already high on entry completes with that same one-cycle latency.
REQ-021 Minimum burst latency SHALL be: start to first load_mem is 1 cycle; load_mem to next load_mem is 2 cycles when done arrives on the first legal cycle.
REQ-022 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-023 done asserted outside WAIT_DONE SHALL be ignored.
REQ-024 ready asserted outside WAIT_READY SHALL be ignored.
REQ-025 load_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 ERR SHALL hold timeout_err=1, keep busy=1 for one cycle, then return to IDLE.
REQ-027 load_mem and complete SHALL never be high in the same cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, load_mem=0, busy=0, complete=0, timeout_err=0 and load_cnt=0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no complete pulse; operation resumes only on a new start after rst_n=1.

Configuration
REQ-030 Macro SEQ_LOAD_TIMEOUT_EN defined: a wait counter SHALL clear on entry to WAIT_DONE or WAIT_READY and count cycles.
REQ-031 With SEQ_LOAD_TIMEOUT_EN defined, reaching TIMEOUT without the awaited input SHALL go to ERR.
REQ-032 Macro SEQ_LOAD_TIMEOUT_EN undefined: there SHALL be no wait counter, waits SHALL be unbounded, ERR SHALL be unreachable and timeout_err SHALL be tied to 0.

Verification
REQ-033 num_loads=3 with done 2 cycles after each load_mem and ready held high -> 3 load_mem pulses, load_cnt steps 1,2,3, one complete pulse, busy then falls.
REQ-034 num_loads=0 with start=1 -> complete on the next cycle, load_mem never asserted, busy stays 0.
REQ-035 num_loads=2 with a second start during WAIT_DONE -> exactly 2 load_mem pulses and a single complete.
REQ-036 TIMEOUT_EN defined with done never asserted -> timeout_err=1 after 15 wait cycles, return to IDLE, no complete; the next start clears timeout_err.
REQ-037 rst_n pulled low in WAIT_READY with num_loads=4 -> all outputs 0 immediately; no complete after release.
REQ-038 done asserted in the same cycle as load_mem and then dropped -> that done is ignored and the block stays in WAIT_DONE.

Source files
------------

// File: rtl/seq_load_initiator.sv
// Load-burst initiator: issues num_loads single-cycle load_mem pulses, each acknowledged by done,
// then waits for ready and pulses complete. Optional wait timeout enabled by SEQ_LOAD_TIMEOUT_EN.
module seq_load_initiator #(
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_loads,
    input  logic             done,
    input  logic             ready,
    output logic             load_mem,
    output logic             busy,
    output logic             complete,
    output logic             timeout_err,
    output logic [CNT_W-1:0] load_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitDone,
        StWaitReady,
        StErr
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic             complete_q, complete_d;

    // One extra bit so load_cnt+1 cannot wrap before the compare against the captured count.
    logic [CNT_W:0]   cnt_inc;
    logic             more_loads;

    assign cnt_inc    = {1'b0, load_cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign more_loads = cnt_inc < {1'b0, target_q};

`ifdef SEQ_LOAD_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_err_q, timeout_err_d;
    logic             wait_expired;

    assign wait_expired = (wait_q == WaitW'(TIMEOUT - 1));
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT == 0);
`endif

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        load_cnt_d = load_cnt_q;
        complete_d = 1'b0;
`ifdef SEQ_LOAD_TIMEOUT_EN
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
`ifdef SEQ_LOAD_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                    if (num_loads != '0) begin
                        target_d   = num_loads;
                        load_cnt_d = '0;
                        state_d    = StLoad;
                    end else begin
                        complete_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                // Any done seen during the load_mem cycle itself is deliberately not sampled.
                state_d = StWaitDone;
`ifdef SEQ_LOAD_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            StWaitDone: begin
                if (done) begin
                    load_cnt_d = (load_cnt_q == CntMax) ? CntMax : cnt_inc[CNT_W-1:0];
                    state_d    = more_loads ? StLoad : StWaitReady;
`ifdef SEQ_LOAD_TIMEOUT_EN
                    wait_d     = '0;
`endif
                end
`ifdef SEQ_LOAD_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d       = StErr;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StWaitReady: begin
                if (ready) begin
                    complete_d = 1'b1;
                    state_d    = StIdle;
                end
`ifdef SEQ_LOAD_TIMEOUT_EN
                else if (wait_expired) begin
                    state_d       = StErr;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            StErr: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            target_q   <= '0;
            load_cnt_q <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            load_cnt_q <= load_cnt_d;
            complete_q <= complete_d;
        end
    end

`ifdef SEQ_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_q        <= wait_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Outputs decode straight from flops so an asynchronous reset clears them at once.
    assign load_mem = (state_q == StLoad);
    assign busy     = (state_q != StIdle);
    assign complete = complete_q;
    assign load_cnt = load_cnt_q;

endmodule

// File: tb/tb_seq_load_initiator.sv
// Directed bench for seq_load_initiator with an event scoreboard for load_mem/complete pulses.
module tb_seq_load_initiator;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_loads;
    logic          done;
    logic          ready;
    logic          load_mem;
    logic          busy;
    logic          complete;
    logic          timeout_err;
    logic [CW-1:0] load_cnt;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            is_cmp;
        bit            chk_cnt;
        logic [CW-1:0] cnt;
    } ev_t;

    ev_t exp_q[$];

    seq_load_initiator #(
        .CNT_W  (CW),
        .TIMEOUT(15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_loads  (num_loads),
        .done       (done),
        .ready      (ready),
        .load_mem   (load_mem),
        .busy       (busy),
        .complete   (complete),
        .timeout_err(timeout_err),
        .load_cnt   (load_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input bit is_cmp, input bit chk_cnt, input logic [CW-1:0] cnt);
        ev_t e;
        e.is_cmp  = is_cmp;
        e.chk_cnt = chk_cnt;
        e.cnt     = cnt;
        exp_q.push_back(e);
    endtask

    task automatic wait_load(input string tag);
        int k;
        k = 0;
        while (load_mem !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, (k < 20), 1);
    endtask

    // Scoreboard: every load_mem or complete pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            check("load_mem_complete_exclusive", {31'b0, load_mem & complete}, 0);
            if (load_mem || complete) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'b0, load_mem, complete}, 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event_kind_is_complete", complete, e.is_cmp);
                    if (e.chk_cnt) check("event_load_cnt", load_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        ready     = 1'b0;
        num_loads = '0;
        #12;
        check("rst_load_mem", load_mem, 0);
        check("rst_busy", busy, 0);
        check("rst_complete", complete, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_load_cnt", load_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Three loads, done two cycles after each load_mem, ready held high.
        ready = 1'b1;
        for (int i = 0; i < 3; i++) push_ev(1'b0, 1'b1, CW'(i));
        push_ev(1'b1, 1'b1, CW'(3));
        start     = 1'b1;
        num_loads = CW'(3);
        tick();
        start = 1'b0;
        check("start_to_load_latency", load_mem, 1);
        for (int i = 0; i < 3; i++) begin
            wait_load("b3_load_wait");
            tick();
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            check("b3_cnt_step", load_cnt, i + 1);
        end
        check("b3_no_early_complete", complete, 0);
        tick();
        check("b3_complete", complete, 1);
        check("b3_busy_fall", busy, 0);
        tick();
        check("b3_complete_single", complete, 0);
        check("b3_queue_drained", exp_q.size(), 0);

        // Zero-length burst.
        push_ev(1'b1, 1'b0, '0);
        start     = 1'b1;
        num_loads = '0;
        tick();
        start = 1'b0;
        check("zero_complete", complete, 1);
        check("zero_no_load", load_mem, 0);
        check("zero_busy", busy, 0);
        tick();
        check("zero_complete_single", complete, 0);
        check("zero_busy_after", busy, 0);
        check("zero_queue_drained", exp_q.size(), 0);

        // Two loads: done alongside load_mem is ignored; restart during WAIT_DONE is dropped.
        ready = 1'b0;
        push_ev(1'b0, 1'b1, CW'(0));
        push_ev(1'b0, 1'b1, CW'(1));
        push_ev(1'b1, 1'b1, CW'(2));
        start     = 1'b1;
        num_loads = CW'(2);
        tick();
        start = 1'b0;
        done  = 1'b1;
        tick();
        done      = 1'b0;
        start     = 1'b1;
        num_loads = CW'(5);
        tick();
        start = 1'b0;
        check("early_done_busy", busy, 1);
        check("early_done_no_load", load_mem, 0);
        check("early_done_cnt", load_cnt, 0);
        tick();
        check("early_done_still_waiting", load_mem, 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("b2_second_load", load_mem, 1);
        check("b2_cnt1", load_cnt, 1);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        check("b2_wait_ready_busy", busy, 1);
        check("b2_wait_ready_no_complete", complete, 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("b2_complete", complete, 1);
        tick();
        check("b2_no_extra_load", load_mem, 0);
        check("b2_complete_single", complete, 0);
        check("b2_queue_drained", exp_q.size(), 0);

        // Fifteen back-to-back loads: two-cycle spacing and load_cnt at its maximum.
        ready = 1'b1;
        for (int i = 0; i < 15; i++) push_ev(1'b0, 1'b1, CW'(i));
        push_ev(1'b1, 1'b1, CW'(15));
        start     = 1'b1;
        num_loads = CW'(15);
        tick();
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("b15_load_spacing", load_mem, 1);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        check("b15_cnt_max", load_cnt, 15);
        tick();
        check("b15_complete", complete, 1);
        tick();
        check("b15_queue_drained", exp_q.size(), 0);
        ready = 1'b0;

`ifdef SEQ_LOAD_TIMEOUT_EN
        // done never arrives: ERR after 15 wait cycles, no complete; next start clears the flag.
        push_ev(1'b0, 1'b1, CW'(0));
        start     = 1'b1;
        num_loads = CW'(1);
        tick();
        start = 1'b0;
        repeat (15) tick();
        check("to_still_waiting", busy, 1);
        check("to_not_yet", timeout_err, 0);
        tick();
        check("to_err_flag", timeout_err, 1);
        check("to_err_busy", busy, 1);
        tick();
        check("to_idle", busy, 0);
        check("to_sticky", timeout_err, 1);
        tick();
        check("to_sticky2", timeout_err, 1);
        check("to_no_complete", complete, 0);
        push_ev(1'b0, 1'b1, CW'(0));
        push_ev(1'b1, 1'b1, CW'(1));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("to_cleared_by_start", timeout_err, 0);
        check("to_restart_load", load_mem, 1);
        tick();
        done = 1'b1;
        tick();
        done  = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("to_restart_complete", complete, 1);
`else
        // Without the timeout, a long wait stays in WAIT_DONE with no error.
        push_ev(1'b0, 1'b1, CW'(0));
        push_ev(1'b1, 1'b1, CW'(1));
        start     = 1'b1;
        num_loads = CW'(1);
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("nto_still_busy", busy, 1);
        check("nto_no_err", timeout_err, 0);
        check("nto_no_load", load_mem, 0);
        done = 1'b1;
        tick();
        done  = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("nto_complete", complete, 1);
`endif
        tick();
        check("pre_reset_queue_drained", exp_q.size(), 0);

        // Reset in WAIT_READY abandons the burst.
        for (int i = 0; i < 4; i++) push_ev(1'b0, 1'b1, CW'(i));
        start     = 1'b1;
        num_loads = CW'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        check("mid_rst_busy_before", busy, 1);
        check("mid_rst_cnt_before", load_cnt, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_load_mem", load_mem, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_complete", complete, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        check("mid_rst_load_cnt", load_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        repeat (5) tick();
        check("post_rst_no_complete", complete, 0);
        check("post_rst_idle", busy, 0);
        check("post_rst_queue_drained", exp_q.size(), 0);
        ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
